// File: rtl/l2_pkg.sv
// Shared L2 command queue types: command codes, command and line-address types.
package l2_pkg;

  typedef logic [1:0]  l2_cmd_t;
  typedef logic [25:0] l2_addr_t;

  localparam l2_cmd_t CMD_READ  = 2'd0;
  localparam l2_cmd_t CMD_WRITE = 2'd1;
  localparam l2_cmd_t CMD_RFO   = 2'd2;
  localparam l2_cmd_t CMD_NOP   = 2'd3;

  // One queue entry is {command, address}.
  localparam int ENTRY_W = $bits(l2_cmd_t) + $bits(l2_addr_t);

endpackage

// File: rtl/l2q_fifo_mem.sv
// DEPTH x 28-bit entry storage for the L2 command queue: one write port and one
// asynchronous read port. Storage is intentionally not reset.
module l2q_fifo_mem
  import l2_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/l2_cmd_queue.sv
// L2 command queue: first-word-fall-through FIFO of {cmd, addr} from the L1s.
// Define L2Q_STATS_EN to build the per-command issue counters.
module l2_cmd_queue
  import l2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_in,
  input  logic [25:0] add_in,
  input  logic        flush,
  input  logic        l2_ready,
  output logic        l2_valid,
  output logic [1:0]  l2_cmd,
  output logic [25:0] l2_add,
  output logic [6:0]  count,
  output logic        full,
  output logic        overflow,
  output logic [31:0] l2_reads,
  output logic [31:0] l2_writes,
  output logic [31:0] l2_rfos
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [6:0]         count_q;
  logic               overflow_q;
  logic               push_req;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // Handshake: an entry transfers downstream on a rising edge where l2_valid
  // and l2_ready are both high; upstream cmd_valid has no back-pressure, so a
  // push that finds the queue full (and no pop that cycle) is dropped and
  // latched in overflow. flush discards everything and suppresses push/pop.
  assign push_req = cmd_valid && (cmd_in != CMD_NOP) && !flush;
  assign pop      = l2_valid && l2_ready && !flush;
  assign push     = push_req && (!full || pop);

  assign l2_valid = (count_q != 7'd0);
  assign full     = (count_q == 7'(DEPTH));
  assign count    = count_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= 7'd0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= 7'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + 7'd1;
        2'b01:   count_q <= count_q - 7'd1;
        default: count_q <= count_q;
      endcase
      if (push_req && full && !pop) overflow_q <= 1'b1;
    end
  end

  l2q_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({cmd_in, add_in}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign l2_cmd = head[ENTRY_W-1 -: 2];
  assign l2_add = head[25:0];

`ifdef L2Q_STATS_EN
  logic [31:0] reads_q;
  logic [31:0] writes_q;
  logic [31:0] rfos_q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      reads_q  <= 32'd0;
      writes_q <= 32'd0;
      rfos_q   <= 32'd0;
    end else if (pop) begin
      case (l2_cmd)
        CMD_READ:  reads_q  <= reads_q + 32'd1;
        CMD_WRITE: writes_q <= writes_q + 32'd1;
        CMD_RFO:   rfos_q   <= rfos_q + 32'd1;
        default:   ;
      endcase
    end
  end

  assign l2_reads  = reads_q;
  assign l2_writes = writes_q;
  assign l2_rfos   = rfos_q;
`else
  assign l2_reads  = 32'd0;
  assign l2_writes = 32'd0;
  assign l2_rfos   = 32'd0;
`endif

endmodule

// File: tb/tb_l2_cmd_queue.sv
// Directed self-checking bench for l2_cmd_queue (DEPTH=8), scoreboard-ordered.
module tb_l2_cmd_queue;

  localparam int DEPTH = 8;
`ifdef L2Q_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        clear;
  logic        cmd_valid;
  logic [1:0]  cmd_in;
  logic [25:0] add_in;
  logic        flush;
  logic        l2_ready;
  logic        l2_valid;
  logic [1:0]  l2_cmd;
  logic [25:0] l2_add;
  logic [6:0]  count;
  logic        full;
  logic        overflow;
  logic [31:0] l2_reads;
  logic [31:0] l2_writes;
  logic [31:0] l2_rfos;

  l2_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .clear     (clear),
    .cmd_valid (cmd_valid),
    .cmd_in    (cmd_in),
    .add_in    (add_in),
    .flush     (flush),
    .l2_ready  (l2_ready),
    .l2_valid  (l2_valid),
    .l2_cmd    (l2_cmd),
    .l2_add    (l2_add),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .l2_reads  (l2_reads),
    .l2_writes (l2_writes),
    .l2_rfos   (l2_rfos)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [27:0] exp_q[$];
  int          checks;
  int          errors;
  int unsigned exp_reads;
  int unsigned exp_writes;
  int unsigned exp_rfos;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_reads"},  l2_reads,  STATS ? exp_reads  : 32'd0);
    check({tag, "_writes"}, l2_writes, STATS ? exp_writes : 32'd0);
    check({tag, "_rfos"},   l2_rfos,   STATS ? exp_rfos   : 32'd0);
  endtask

  // Drivers
  task automatic push_one(input logic [1:0] c, input logic [25:0] a);
    cmd_valid = 1'b1;
    cmd_in    = c;
    add_in    = a;
    step();
    cmd_valid = 1'b0;
    if (c != 2'd3 && exp_q.size() < DEPTH) exp_q.push_back({c, a});
  endtask

  task automatic count_issue(input logic [1:0] c);
    case (c)
      2'd0: exp_reads++;
      2'd1: exp_writes++;
      2'd2: exp_rfos++;
      default: ;
    endcase
  endtask

  task automatic pop_one();
    logic [27:0] e;
    e = exp_q.pop_front();
    check("head_valid", {31'd0, l2_valid}, 32'd1);
    check("head_cmd", {30'd0, l2_cmd}, {30'd0, e[27:26]});
    check("head_add", {6'd0, l2_add}, {6'd0, e[25:0]});
    l2_ready = 1'b1;
    step();
    l2_ready = 1'b0;
    count_issue(e[27:26]);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() != 0) pop_one();
    check({tag, "_count0"}, {25'd0, count}, 32'd0);
    check({tag, "_valid0"}, {31'd0, l2_valid}, 32'd0);
  endtask

  initial begin
    logic [27:0] e;
    checks = 0; errors = 0;
    exp_reads = 0; exp_writes = 0; exp_rfos = 0;
    clear = 1'b0; cmd_valid = 1'b0; cmd_in = 2'd0; add_in = '0;
    flush = 1'b0; l2_ready = 1'b0;

    // Reset state
    #3;
    check("rst_count", {25'd0, count}, 32'd0);
    check("rst_valid", {31'd0, l2_valid}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check_stats("rst");
    repeat (2) @(posedge clk);
    #1 clear = 1'b1;

    // First push, FWFT latency, no bypass
    cmd_valid = 1'b1; cmd_in = 2'd0; add_in = 26'h0000123;
    #1 check("no_bypass_valid", {31'd0, l2_valid}, 32'd0);
    step();
    cmd_valid = 1'b0;
    check("first_valid", {31'd0, l2_valid}, 32'd1);
    check("first_cmd", {30'd0, l2_cmd}, 32'd0);
    check("first_add", {6'd0, l2_add}, 32'h0000123);
    check("first_count", {25'd0, count}, 32'd1);
    exp_q.push_back({2'd0, 26'h0000123});
    drain("first");

    // l2_ready while empty
    l2_ready = 1'b1;
    step();
    l2_ready = 1'b0;
    check("empty_ready_count", {25'd0, count}, 32'd0);

    // Full, push + pop same cycle
    for (int i = 0; i < DEPTH; i++) push_one(2'd0, 26'h200 + 26'(i));
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_count", {25'd0, count}, 32'd8);
    e = exp_q.pop_front();
    check("pp_head_add", {6'd0, l2_add}, {6'd0, e[25:0]});
    cmd_valid = 1'b1; cmd_in = 2'd2; add_in = 26'h3FFFFFF; l2_ready = 1'b1;
    step();
    cmd_valid = 1'b0; l2_ready = 1'b0;
    count_issue(e[27:26]);
    exp_q.push_back({2'd2, 26'h3FFFFFF});
    check("pp_count", {25'd0, count}, 32'd8);
    check("pp_overflow", {31'd0, overflow}, 32'd0);
    check("pp_full", {31'd0, full}, 32'd1);
    drain("pp");

    // Full, push dropped, overflow sticky
    for (int i = 0; i < DEPTH; i++) push_one(2'(i % 3), 26'h100 + 26'(i));
    check("ovf_full", {31'd0, full}, 32'd1);
    check("ovf_pre", {31'd0, overflow}, 32'd0);
    push_one(2'd1, 26'h2AA);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    check("ovf_count", {25'd0, count}, 32'd8);
    drain("ovf");
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check_stats("ovf");

    // NOP never enqueued
    push_one(2'd3, 26'h77);
    check("nop_count", {25'd0, count}, 32'd0);
    check("nop_valid", {31'd0, l2_valid}, 32'd0);

    // Flush with simultaneous push and ready
    push_one(2'd0, 26'h11);
    push_one(2'd1, 26'h22);
    push_one(2'd2, 26'h33);
    check("pre_flush_count", {25'd0, count}, 32'd3);
    flush = 1'b1; cmd_valid = 1'b1; cmd_in = 2'd0; add_in = 26'h55; l2_ready = 1'b1;
    step();
    flush = 1'b0; cmd_valid = 1'b0; l2_ready = 1'b0;
    exp_q.delete();
    check("flush_count", {25'd0, count}, 32'd0);
    check("flush_valid", {31'd0, l2_valid}, 32'd0);
    check("flush_overflow", {31'd0, overflow}, 32'd1);
    check_stats("flush");

    // Asynchronous clear mid-cycle with 5 entries
    for (int i = 0; i < 5; i++) push_one(2'd2, 26'h400 + 26'(i));
    check("pre_clear_count", {25'd0, count}, 32'd5);
    #2 clear = 1'b0;
    #1;
    check("aclr_count", {25'd0, count}, 32'd0);
    check("aclr_valid", {31'd0, l2_valid}, 32'd0);
    check("aclr_full", {31'd0, full}, 32'd0);
    check("aclr_overflow", {31'd0, overflow}, 32'd0);
    exp_q.delete();
    exp_reads = 0; exp_writes = 0; exp_rfos = 0;
    check_stats("aclr");
    @(posedge clk);
    #1 clear = 1'b1;

    // Issue-counter mix: 2 READ, 1 WRITE, 3 RFO, 1 NOP
    push_one(2'd0, 26'h1000);
    push_one(2'd2, 26'h1001);
    push_one(2'd3, 26'h1002);
    push_one(2'd1, 26'h1003);
    push_one(2'd0, 26'h1004);
    push_one(2'd2, 26'h1005);
    push_one(2'd2, 26'h1006);
    check("mix_count", {25'd0, count}, 32'd6);
    drain("mix");
    check("mix_reads", l2_reads, STATS ? 32'd2 : 32'd0);
    check("mix_writes", l2_writes, STATS ? 32'd1 : 32'd0);
    check("mix_rfos", l2_rfos, STATS ? 32'd3 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
